// File: rtl/dvi_timing_ctrl_if.sv
// -----------------------------------------------------------------------------
// dvi_timing_ctrl_if
// Upstream pixel stream between a pixel source and the DVI timing controller.
//   pix_valid              : source has a pixel available
//   pix_red/green/blue     : 8-bit colour components of that pixel
//   pix_ready              : sink consumes the pixel this cycle
// A transfer happens in every cycle where pix_valid & pix_ready.
// Modports: master = pixel source, slave = timing controller.
// -----------------------------------------------------------------------------
interface dvi_timing_ctrl_if;
   logic       pix_valid;
   logic [7:0] pix_red;
   logic [7:0] pix_green;
   logic [7:0] pix_blue;
   logic       pix_ready;

   modport master (output pix_valid, pix_red, pix_green, pix_blue,
                   input  pix_ready);
   modport slave  (input  pix_valid, pix_red, pix_green, pix_blue,
                   output pix_ready);
endinterface

// File: rtl/dvi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// dvi_timing_ctrl
// Video timing controller for a DVI transmitter. Generates horizontal/vertical
// timing (active, front porch, sync, back porch), pulls pixels from an upstream
// valid/ready stream and drives registered RGB, hsync, vsync and data enable.
// Run control: start/stop pulses with an optional frame count (0 = continuous).
//
// Ports:
//   clock, reset_n       pixel clock, asynchronous active-low reset
//   start, stop          one-cycle run-control pulses
//   frame_count[15:0]    frames per start (0 = continuous), sampled on start
//   pattern_en           colour-bar generator select (optional build only)
//   pix                  upstream pixel stream (dvi_timing_ctrl_if.slave)
//   red/green/blue[7:0]  registered pixel towards the DVI transmitter
//   hsync, vsync, de     registered sync and data-enable
//   x, y [10:0]          position of the current output pixel (0 when de=0)
//   busy                 high while running or stopping
//   frame_done           one-cycle pulse after the last clock of each frame
//   underflow            sticky: an active pixel found no upstream data
//
// Build option: define DVI_CTRL_PATTERN_EN to add the pattern_en input and
// the 8-bar colour pattern generator.
// -----------------------------------------------------------------------------
module dvi_timing_ctrl #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int SYNC_POL = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stop,
   input  logic [15:0]        frame_count,
`ifdef DVI_CTRL_PATTERN_EN
   input  logic               pattern_en,
`endif
   dvi_timing_ctrl_if.slave   pix,
   output logic [7:0]         red,
   output logic [7:0]         green,
   output logic [7:0]         blue,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [10:0]        x,
   output logic [10:0]        y,
   output logic               busy,
   output logic               frame_done,
   output logic               underflow
);

   localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
   localparam logic [10:0] H_TOT   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
   localparam logic [10:0] V_TOT   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        SYNC_ON = (SYNC_POL != 0);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] hcnt_q, hcnt_d;
   logic [10:0] vcnt_q, vcnt_d;
   logic [15:0] frames_left_q, frames_left_d;
   logic        underflow_q, underflow_d;
   logic [7:0]  red_q, red_d;
   logic [7:0]  green_q, green_d;
   logic [7:0]  blue_q, blue_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        de_q, de_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;

   logic        running;
   logic        active;
   logic        frame_end;

`ifdef DVI_CTRL_PATTERN_EN
   logic        pattern_q, pattern_d;
   logic [13:0] bar_num;
   logic [2:0]  bar;

   // Bar index = x*8/H_ACTIVE; divisor is a constant.
   assign bar_num = {hcnt_q, 3'b000};
   assign bar     = 3'(bar_num / 14'(H_ACTIVE));
`endif

   assign running   = (state_q != ST_IDLE);
   assign active    = running && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
   assign frame_end = running && (hcnt_q == H_TOT - 11'd1)
                              && (vcnt_q == V_TOT - 11'd1);

`ifdef DVI_CTRL_PATTERN_EN
   assign pix.pix_ready = active && !pattern_q;
`else
   assign pix.pix_ready = active;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         frames_left_q <= '0;
         underflow_q   <= 1'b0;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
         hsync_q       <= ~SYNC_ON;
         vsync_q       <= ~SYNC_ON;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
`ifdef DVI_CTRL_PATTERN_EN
         pattern_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         frames_left_q <= frames_left_d;
         underflow_q   <= underflow_d;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
`ifdef DVI_CTRL_PATTERN_EN
         pattern_q     <= pattern_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      frames_left_d = frames_left_q;
      underflow_d   = underflow_q;
`ifdef DVI_CTRL_PATTERN_EN
      pattern_d     = pattern_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // start beats a simultaneous stop: stop is simply not looked at here.
            if (start) begin
               state_d       = ST_RUN;
               frames_left_d = frame_count;
               underflow_d   = 1'b0;
`ifdef DVI_CTRL_PATTERN_EN
               pattern_d     = pattern_en;
`endif
            end
         end
         ST_RUN: begin
            if (frame_end) begin
               // frames_left of 0 means continuous: never decremented.
               if (frames_left_q != 16'd0) frames_left_d = frames_left_q - 16'd1;
               // A stop on the very last clock has nothing left to finish.
               if (stop || frames_left_q == 16'd1) state_d = ST_IDLE;
            end else if (stop) begin
               state_d = ST_STOPPING;
            end
         end
         ST_STOPPING: begin
            if (frame_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Counters sit at the origin while idle so every run starts at (0,0).
      if (running) begin
         if (hcnt_q == H_TOT - 11'd1) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_TOT - 11'd1) ? 11'd0 : vcnt_q + 11'd1;
         end else begin
            hcnt_d = hcnt_q + 11'd1;
         end
      end else begin
         hcnt_d = '0;
         vcnt_d = '0;
      end

`ifdef DVI_CTRL_PATTERN_EN
      // Pattern mode latches pattern_en only at a frame boundary.
      if (frame_end) pattern_d = pattern_en;
      if (active && !pattern_q && !pix.pix_valid) underflow_d = 1'b1;
`else
      if (active && !pix.pix_valid) underflow_d = 1'b1;
`endif

      // Output stage: registered image of the current counter position.
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
`ifdef DVI_CTRL_PATTERN_EN
      if (active && pattern_q) begin
         // white, yellow, cyan, green, magenta, red, blue, black
         red_d   = {8{~bar[1]}};
         green_d = {8{~bar[2]}};
         blue_d  = {8{~bar[0]}};
      end else if (active && pix.pix_valid) begin
         red_d   = pix.pix_red;
         green_d = pix.pix_green;
         blue_d  = pix.pix_blue;
      end
`else
      if (active && pix.pix_valid) begin
         red_d   = pix.pix_red;
         green_d = pix.pix_green;
         blue_d  = pix.pix_blue;
      end
`endif
      de_d         = active;
      x_d          = active ? hcnt_q : 11'd0;
      y_d          = active ? vcnt_q : 11'd0;
      hsync_d      = (running && hcnt_q >= HS_BEG && hcnt_q < HS_END) ? SYNC_ON : ~SYNC_ON;
      vsync_d      = (running && vcnt_q >= VS_BEG && vcnt_q < VS_END) ? SYNC_ON : ~SYNC_ON;
      frame_done_d = frame_end;
      busy_d       = (state_d != ST_IDLE);
   end

   assign red        = red_q;
   assign green      = green_q;
   assign blue       = blue_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign de         = de_q;
   assign x          = x_q;
   assign y          = y_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dvi_timing_ctrl
// Directed bench for dvi_timing_ctrl with a small 16x8 raster
// (8+2+3+3 clocks per line, 4+1+2+1 lines per frame, 128 clocks per frame).
// Position k after the start edge maps to hcnt=k%16, vcnt=(k/16)%8; the
// outputs for position k are visible just after the following rising edge.
// Active upstream pixels carry red=8*v+h, green=~red, blue=red^8'h5A.
// -----------------------------------------------------------------------------
module tb_dvi_timing_ctrl;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] frame_count = 16'd0;
`ifdef DVI_CTRL_PATTERN_EN
  logic        pattern_en = 1'b0;
`endif
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, de, busy, frame_done, underflow;
  logic [10:0] x, y;
  logic [51:0] act_vec;

  int errors = 0;
  int checks = 0;

  dvi_timing_ctrl_if pix_if ();

  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .frame_count(frame_count),
`ifdef DVI_CTRL_PATTERN_EN
    .pattern_en (pattern_en),
`endif
    .pix        (pix_if),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  always #5 clock = ~clock;

  assign act_vec = {de, hsync, vsync, frame_done, busy, underflow, x, y, red, green, blue};

  // Expected output vector for raster position k.
  function automatic logic [51:0] exp_vec(input int k, input logic fd,
                                          input logic bz, input logic uf);
    int h = k % HT;
    int v = (k / HT) % VT;
    logic act = (h < HA) && (v < VA);
    logic hs  = (h >= HA + HF) && (h < HA + HF + HS);
    logic vs  = (v >= VA + VF) && (v < VA + VF + VS);
    logic [7:0] r = act ? 8'(8 * v + h) : 8'h00;
    logic [7:0] g = act ? ~8'(8 * v + h) : 8'h00;
    logic [7:0] b = act ? (8'(8 * v + h) ^ 8'h5A) : 8'h00;
    return {act, hs, vs, fd, bz, uf, act ? 11'(h) : 11'd0, act ? 11'(v) : 11'd0, r, g, b};
  endfunction

  task automatic drive_pix(input int k, input logic valid);
    int h = k % HT;
    int v = (k / HT) % VT;
    logic [7:0] r = ((h < HA) && (v < VA)) ? 8'(8 * v + h) : 8'hEE;
    pix_if.pix_valid = valid;
    pix_if.pix_red   = r;
    pix_if.pix_green = ~r;
    pix_if.pix_blue  = r ^ 8'h5A;
  endtask

  // Drives a start pulse (optionally with stop) and returns #1 after the
  // edge that samples it.
  task automatic start_pulse(input logic [15:0] fc, input logic with_stop);
    @(negedge clock);
    start = 1'b1;
    stop = with_stop;
    frame_count = fc;
    @(posedge clock);
    #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_reset;
    drive_pix(0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({act_vec, pix_if.pix_ready} !== 53'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h required 0", {act_vec, pix_if.pix_ready});
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({act_vec, pix_if.pix_ready} !== 53'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h required 0", {act_vec, pix_if.pix_ready});
    end
  endtask

  task automatic test_single_frame;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fd_cnt = 0;
    start_pulse(16'd1, 1'b0);
    checks++;
    if (de !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_edge: de=%b busy=%b required de=0 busy=1", de, busy);
    end
    for (int k = 0; k < FT; k++) begin
      int h = k % HT;
      int v = k / HT;
      @(negedge clock);
      drive_pix(k, 1'b1);
      #1;
      checks++;
      if (pix_if.pix_ready !== ((h < HA) && (v < VA))) begin
        errors++;
        $display("FAIL frame_ready k=%0d: got %b required %b", k, pix_if.pix_ready,
                 (h < HA) && (v < VA));
      end
      @(posedge clock);
      #1;
      checks++;
      if (act_vec !== exp_vec(k, k == FT - 1, k != FT - 1, 1'b0)) begin
        errors++;
        $display("FAIL frame_out k=%0d: got %h required %h", k, act_vec,
                 exp_vec(k, k == FT - 1, k != FT - 1, 1'b0));
      end
      de_cnt += int'(de);
      hs_cnt += int'(hsync);
      vs_cnt += int'(vsync);
      fd_cnt += int'(frame_done);
    end
    checks++;
    if (de_cnt != 32 || hs_cnt != 24 || vs_cnt != 32 || fd_cnt != 1) begin
      errors++;
      $display("FAIL frame_counts: de=%0d hs=%0d vs=%0d fd=%0d required 32 24 32 1",
               de_cnt, hs_cnt, vs_cnt, fd_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({de, busy, frame_done, pix_if.pix_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL after_frame_idle: de/busy/fd/rdy=%b required 0000",
                 {de, busy, frame_done, pix_if.pix_ready});
      end
    end
  endtask

  task automatic test_underflow;
    start_pulse(16'd1, 1'b0);
    for (int k = 0; k < FT; k++) begin
      @(negedge clock);
      drive_pix(k, k != 19);
      @(posedge clock);
      #1;
      if (k == 18) begin
        checks++;
        if (underflow !== 1'b0) begin
          errors++;
          $display("FAIL underflow_early: got %b required 0", underflow);
        end
      end
      if (k == 19) begin
        checks++;
        if ({de, x, y, red, green, blue, underflow} !== {1'b1, 11'd3, 11'd1, 24'd0, 1'b1}) begin
          errors++;
          $display("FAIL underflow_pixel: de=%b x=%0d y=%0d rgb=%h uf=%b required 1 3 1 000000 1",
                   de, x, y, {red, green, blue}, underflow);
        end
      end
      if (k == 20) begin
        checks++;
        if (act_vec !== exp_vec(k, 1'b0, 1'b1, 1'b1)) begin
          errors++;
          $display("FAIL underflow_next: got %h required %h", act_vec, exp_vec(k, 1'b0, 1'b1, 1'b1));
        end
      end
    end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (underflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL underflow_sticky: uf=%b busy=%b required 1 0", underflow, busy);
    end
    // Restart clears underflow; a start while busy must be ignored.
    start_pulse(16'd1, 1'b0);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: got %b required 0", underflow);
    end
    for (int k = 0; k < FT; k++) begin
      @(negedge clock);
      drive_pix(k, 1'b1);
      start = (k == 50);
      frame_count = (k == 50) ? 16'd5 : 16'd1;
      @(posedge clock);
      #1;
      if (k == FT - 2 || k == FT - 1) begin
        checks++;
        if ({busy, frame_done} !== ((k == FT - 1) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL start_busy_ignored k=%0d: busy/fd=%b required %b", k, {busy, frame_done},
                   (k == FT - 1) ? 2'b01 : 2'b10);
        end
      end
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_idle_controls;
    int fd_cnt = 0;
    @(negedge clock);
    stop = 1'b1;
    @(posedge clock);
    #1;
    stop = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || de !== 1'b0) begin
      errors++;
      $display("FAIL stop_in_idle: busy=%b de=%b required 0 0", busy, de);
    end
    start_pulse(16'd2, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_stop_same: busy=%b required 1", busy);
    end
    for (int k = 0; k < 2 * FT; k++) begin
      @(negedge clock);
      drive_pix(k, 1'b1);
      @(posedge clock);
      #1;
      fd_cnt += int'(frame_done);
      if (k == FT - 1 || k == 2 * FT - 1) begin
        checks++;
        if ({busy, frame_done} !== {k == FT - 1, 1'b1}) begin
          errors++;
          $display("FAIL two_frames k=%0d: busy/fd=%b required %b", k, {busy, frame_done},
                   {k == FT - 1, 1'b1});
        end
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL two_frames_count: got %0d required 2", fd_cnt);
    end
  endtask

  task automatic test_continuous_stop;
    int fd_cnt = 0;
    int idle_k = -1;
    start_pulse(16'd0, 1'b0);
    for (int k = 0; k < 2 * FT + 20; k++) begin
      @(negedge clock);
      drive_pix(k, 1'b1);
      stop = (k == FT + 40);
      @(posedge clock);
      #1;
      fd_cnt += int'(frame_done);
      if (busy === 1'b0 && idle_k < 0) idle_k = k;
      if (k == FT - 1) begin
        checks++;
        if ({busy, frame_done} !== 2'b11) begin
          errors++;
          $display("FAIL continuous_frame1: busy/fd=%b required 11", {busy, frame_done});
        end
      end
    end
    stop = 1'b0;
    checks++;
    if (fd_cnt != 2 || idle_k != 2 * FT - 1) begin
      errors++;
      $display("FAIL stop_mid_frame2: fd=%0d idle_at=%0d required 2 %0d", fd_cnt, idle_k, 2 * FT - 1);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    start_pulse(16'd0, 1'b0);
    for (int k = 0; k < 37; k++) begin
      @(negedge clock);
      drive_pix(k, 1'b1);
      @(posedge clock);
    end
    @(negedge clock);
    drive_pix(37, 1'b1);
    #1;
    checks++;
    if (de !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_active: de=%b busy=%b required 1 1", de, busy);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({act_vec, pix_if.pix_ready} !== 53'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {act_vec, pix_if.pix_ready});
    end
    @(negedge clock);
    reset_n = 1'b1;
    start_pulse(16'd1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      drive_pix(k, 1'b1);
      @(posedge clock);
      #1;
      checks++;
      if (act_vec !== exp_vec(k, 1'b0, 1'b1, 1'b0)) begin
        errors++;
        $display("FAIL restart_origin k=%0d: got %h required %h", k, act_vec, exp_vec(k, 1'b0, 1'b1, 1'b0));
      end
    end
    while (busy === 1'b1 && n < 200) begin
      @(negedge clock);
      drive_pix(n + 2, 1'b1);
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_complete: busy=%b after %0d cycles required 0", busy, n);
    end
  endtask

`ifdef DVI_CTRL_PATTERN_EN
  task automatic test_pattern;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    pattern_en = 1'b1;
    start_pulse(16'd1, 1'b0);
    for (int k = 0; k < FT; k++) begin
      int h = k % HT;
      int v = k / HT;
      @(negedge clock);
      drive_pix(k, 1'b0);
      #1;
      checks++;
      if (pix_if.pix_ready !== 1'b0) begin
        errors++;
        $display("FAIL pattern_ready k=%0d: got %b required 0", k, pix_if.pix_ready);
      end
      @(posedge clock);
      #1;
      if (h < HA && v < VA) begin
        checks++;
        if ({de, red, green, blue} !== {1'b1, bars[h * 8 / HA]}) begin
          errors++;
          $display("FAIL pattern_bar x=%0d y=%0d: got %h required %h", h, v,
                   {de, red, green, blue}, {1'b1, bars[h * 8 / HA]});
        end
      end
    end
    checks++;
    if (underflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pattern_underflow: uf=%b busy=%b required 0 0", underflow, busy);
    end
    pattern_en = 1'b0;
  endtask
`endif

  initial begin
    pix_if.pix_valid = 1'b0;
    pix_if.pix_red   = 8'h00;
    pix_if.pix_green = 8'h00;
    pix_if.pix_blue  = 8'h00;
    test_reset();
    test_single_frame();
    test_underflow();
    test_idle_controls();
    test_continuous_stop();
    test_reset_mid();
`ifdef DVI_CTRL_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
